// File: rtl/vec_store_sequencer_if.sv
// Request and data-memory write bundle for vec_store_sequencer.
// The req_mask signal exists only when VSTORE_MASK_EN is defined.
interface vec_store_sequencer_if #(
   parameter int LANES = 5
);
   logic                  req_valid;
   logic                  req_ready;
   logic [31:0]           req_base;
   logic [3:0]            req_len;
   logic [LANES*32-1:0]   req_data;
`ifdef VSTORE_MASK_EN
   logic [LANES-1:0]      req_mask;
`endif
   logic                  mem_we;
   logic [31:0]           mem_adr;
   logic [31:0]           mem_wd;
   logic                  busy;
   logic                  done;

`ifdef VSTORE_MASK_EN
   modport master (
      output req_valid, req_base, req_len, req_data, req_mask,
      input  req_ready, mem_we, mem_adr, mem_wd, busy, done
   );
   modport slave (
      input  req_valid, req_base, req_len, req_data, req_mask,
      output req_ready, mem_we, mem_adr, mem_wd, busy, done
   );
`else
   modport master (
      output req_valid, req_base, req_len, req_data,
      input  req_ready, mem_we, mem_adr, mem_wd, busy, done
   );
   modport slave (
      input  req_valid, req_base, req_len, req_data,
      output req_ready, mem_we, mem_adr, mem_wd, busy, done
   );
`endif
endinterface

// File: rtl/vec_store_sequencer.sv
// Serialises a LANES-wide vector store into single-word dmem writes, stalling the core via busy.
// Optional per-lane write mask enabled by defining VSTORE_MASK_EN.
module vec_store_sequencer #(
   parameter int LANES  = 5,
   parameter int STRIDE = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   vec_store_sequencer_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

   localparam logic [3:0]  LANES_L  = 4'(LANES);
   localparam logic [31:0] STRIDE_L = 32'(STRIDE);

   state_t                state_q;
   logic [3:0]            lane_q;
   logic [3:0]            len_q;
   logic [LANES*32-1:0]   data_q;
   logic                  mem_we_q;
   logic [31:0]           mem_adr_q;
   logic [31:0]           mem_wd_q;
   logic                  done_q;
   logic                  ready_q;
   logic                  busy_q;

   logic [3:0]            len_d;
   logic [31:0]           adr_d;
   logic                  first_we_d;
   logic                  next_we_d;

   assign len_d = (bus.req_len > LANES_L) ? LANES_L : bus.req_len;
   assign adr_d = mem_adr_q + STRIDE_L;

`ifdef VSTORE_MASK_EN
   logic [LANES-1:0]      mask_q;
   assign first_we_d = bus.req_mask[0];
   assign next_we_d  = mask_q[0];
`else
   assign first_we_d = 1'b1;
   assign next_we_d  = 1'b1;
`endif

   // Captured lanes are shifted down so the next word to write always sits in bits [31:0].
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         lane_q    <= '0;
         len_q     <= '0;
         data_q    <= '0;
         mem_we_q  <= 1'b0;
         mem_adr_q <= '0;
         mem_wd_q  <= '0;
         done_q    <= 1'b0;
         ready_q   <= 1'b1;
         busy_q    <= 1'b0;
`ifdef VSTORE_MASK_EN
         mask_q    <= '0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.req_valid) begin
                  mem_adr_q <= {bus.req_base[31:2], 2'b00};
                  mem_wd_q  <= bus.req_data[31:0];
                  data_q    <= bus.req_data >> 32;
                  lane_q    <= '0;
                  len_q     <= len_d;
                  ready_q   <= 1'b0;
                  busy_q    <= 1'b1;
`ifdef VSTORE_MASK_EN
                  mask_q    <= bus.req_mask >> 1;
`endif
                  if (len_d == 4'd0) begin
                     state_q  <= DONE;
                     done_q   <= 1'b1;
                     mem_we_q <= 1'b0;
                  end else begin
                     state_q  <= WRITE;
                     mem_we_q <= first_we_d;
                  end
               end
            end
            WRITE: begin
               if (lane_q == len_q - 4'd1) begin
                  state_q  <= DONE;
                  mem_we_q <= 1'b0;
                  done_q   <= 1'b1;
               end else begin
                  // Masked lanes still advance the address so timing matches the unmasked case.
                  lane_q    <= lane_q + 4'd1;
                  mem_adr_q <= adr_d;
                  mem_wd_q  <= data_q[31:0];
                  data_q    <= data_q >> 32;
                  mem_we_q  <= next_we_d;
`ifdef VSTORE_MASK_EN
                  mask_q    <= mask_q >> 1;
`endif
               end
            end
            DONE: begin
               state_q <= IDLE;
               done_q  <= 1'b0;
               ready_q <= 1'b1;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q  <= IDLE;
               mem_we_q <= 1'b0;
               done_q   <= 1'b0;
               ready_q  <= 1'b1;
               busy_q   <= 1'b0;
            end
         endcase
      end
   end

   assign bus.req_ready = ready_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_adr   = mem_adr_q;
   assign bus.mem_wd    = mem_wd_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
endmodule

// File: tb/tb_vec_store_sequencer.sv
// Directed self-checking bench for vec_store_sequencer (LANES=5, STRIDE=4).
// Mask scenario runs only when VSTORE_MASK_EN is defined.
module tb_vec_store_sequencer;
   localparam int LANES = 5;

   logic clk;
   logic reset;
   int   checks;
   int   errors;

   vec_store_sequencer_if #(.LANES(LANES)) vif ();

   vec_store_sequencer #(.LANES(LANES), .STRIDE(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (vif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [LANES*32-1:0] pack5(input logic [31:0] w0, w1, w2, w3, w4);
      return {w4, w3, w2, w1, w0};
   endfunction

   // Drives one request for a single accepting edge; no checking here.
   task automatic issue(input logic [31:0] base, input logic [3:0] len, input logic [LANES*32-1:0] data);
      vif.req_valid = 1'b1;
      vif.req_base  = base;
      vif.req_len   = len;
      vif.req_data  = data;
      tick();
      vif.req_valid = 1'b0;
      vif.req_data  = '1;
      vif.req_base  = 32'hDEAD_BEE0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      #12;
      checks++;
      if (vif.req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", vif.req_ready); end
      checks++;
      if (vif.busy !== 1'b0 || vif.done !== 1'b0 || vif.mem_we !== 1'b0) begin
         errors++; $display("FAIL reset_ctl got busy=%b done=%b we=%b want 0 0 0", vif.busy, vif.done, vif.mem_we);
      end
      checks++;
      if (vif.mem_adr !== 32'h0 || vif.mem_wd !== 32'h0) begin
         errors++; $display("FAIL reset_bus got adr=%h wd=%h want 0 0", vif.mem_adr, vif.mem_wd);
      end
      @(negedge clk);
      reset = 1'b0;
      tick();
      $display("reset: ready=%b busy=%b", vif.req_ready, vif.busy);
   endtask

   task automatic test_basic();
      logic [31:0] words [5] = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h55};
      issue(32'h100, 4'd5, pack5(words[0], words[1], words[2], words[3], words[4]));
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (vif.mem_we !== 1'b1 || vif.mem_adr !== 32'h100 + 32'(4*i) || vif.mem_wd !== words[i]) begin
            errors++;
            $display("FAIL basic_lane%0d got we=%b adr=%h wd=%h want 1 %h %h",
                     i, vif.mem_we, vif.mem_adr, vif.mem_wd, 32'h100 + 32'(4*i), words[i]);
         end
         checks++;
         if (vif.busy !== 1'b1 || vif.req_ready !== 1'b0) begin
            errors++; $display("FAIL basic_busy%0d got busy=%b ready=%b want 1 0", i, vif.busy, vif.req_ready);
         end
         $display("basic: lane %0d we=%b adr=%h wd=%h", i, vif.mem_we, vif.mem_adr, vif.mem_wd);
         tick();
      end
      checks++;
      if (vif.done !== 1'b1 || vif.mem_we !== 1'b0 || vif.req_ready !== 1'b0) begin
         errors++; $display("FAIL basic_done got done=%b we=%b ready=%b want 1 0 0", vif.done, vif.mem_we, vif.req_ready);
      end
      checks++;
      if (vif.mem_adr !== 32'h110 || vif.mem_wd !== 32'h55) begin
         errors++; $display("FAIL basic_hold got adr=%h wd=%h want 110 55", vif.mem_adr, vif.mem_wd);
      end
      tick();
      checks++;
      if (vif.done !== 1'b0 || vif.req_ready !== 1'b1 || vif.busy !== 1'b0) begin
         errors++; $display("FAIL basic_idle got done=%b ready=%b busy=%b want 0 1 0", vif.done, vif.req_ready, vif.busy);
      end
   endtask

   task automatic test_zero_len();
      issue(32'h180, 4'd0, pack5(32'h1, 32'h2, 32'h3, 32'h4, 32'h5));
      checks++;
      if (vif.mem_we !== 1'b0 || vif.done !== 1'b1 || vif.busy !== 1'b1) begin
         errors++; $display("FAIL zero_done got we=%b done=%b busy=%b want 0 1 1", vif.mem_we, vif.done, vif.busy);
      end
      $display("zero: done=%b we=%b", vif.done, vif.mem_we);
      tick();
      checks++;
      if (vif.mem_we !== 1'b0 || vif.done !== 1'b0 || vif.busy !== 1'b0 || vif.req_ready !== 1'b1) begin
         errors++; $display("FAIL zero_idle got we=%b done=%b busy=%b ready=%b want 0 0 0 1",
                            vif.mem_we, vif.done, vif.busy, vif.req_ready);
      end
   endtask

   task automatic test_clamp_align();
      logic [31:0] words [5] = '{32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hA4};
      issue(32'h203, 4'd9, pack5(words[0], words[1], words[2], words[3], words[4]));
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (vif.mem_we !== 1'b1 || vif.mem_adr !== 32'h200 + 32'(4*i) || vif.mem_wd !== words[i]) begin
            errors++;
            $display("FAIL clamp_lane%0d got we=%b adr=%h wd=%h want 1 %h %h",
                     i, vif.mem_we, vif.mem_adr, vif.mem_wd, 32'h200 + 32'(4*i), words[i]);
         end
         $display("clamp: lane %0d adr=%h wd=%h", i, vif.mem_adr, vif.mem_wd);
         tick();
      end
      checks++;
      if (vif.mem_we !== 1'b0 || vif.done !== 1'b1) begin
         errors++; $display("FAIL clamp_done got we=%b done=%b want 0 1", vif.mem_we, vif.done);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      vif.req_valid = 1'b1;
      vif.req_base  = 32'h300;
      vif.req_len   = 4'd2;
      vif.req_data  = pack5(32'hB0, 32'hB1, 32'h0, 32'h0, 32'h0);
      tick();
      // Second request held from here on; its payload differs from the first.
      vif.req_base  = 32'h400;
      vif.req_data  = pack5(32'hC0, 32'hC1, 32'h0, 32'h0, 32'h0);
      checks++;
      if (vif.mem_we !== 1'b1 || vif.mem_adr !== 32'h300 || vif.mem_wd !== 32'hB0) begin
         errors++; $display("FAIL b2b_a0 got we=%b adr=%h wd=%h want 1 300 b0", vif.mem_we, vif.mem_adr, vif.mem_wd);
      end
      tick();
      checks++;
      if (vif.mem_we !== 1'b1 || vif.mem_adr !== 32'h304 || vif.mem_wd !== 32'hB1) begin
         errors++; $display("FAIL b2b_a1 got we=%b adr=%h wd=%h want 1 304 b1", vif.mem_we, vif.mem_adr, vif.mem_wd);
      end
      tick();
      checks++;
      if (vif.done !== 1'b1 || vif.mem_we !== 1'b0 || vif.req_ready !== 1'b0) begin
         errors++; $display("FAIL b2b_done got done=%b we=%b ready=%b want 1 0 0", vif.done, vif.mem_we, vif.req_ready);
      end
      tick();
      checks++;
      if (vif.req_ready !== 1'b1 || vif.mem_we !== 1'b0 || vif.busy !== 1'b0) begin
         errors++; $display("FAIL b2b_gap got ready=%b we=%b busy=%b want 1 0 0", vif.req_ready, vif.mem_we, vif.busy);
      end
      tick();
      vif.req_valid = 1'b0;
      vif.req_data  = '1;
      checks++;
      if (vif.mem_we !== 1'b1 || vif.mem_adr !== 32'h400 || vif.mem_wd !== 32'hC0) begin
         errors++; $display("FAIL b2b_b0 got we=%b adr=%h wd=%h want 1 400 c0", vif.mem_we, vif.mem_adr, vif.mem_wd);
      end
      tick();
      checks++;
      if (vif.mem_we !== 1'b1 || vif.mem_adr !== 32'h404 || vif.mem_wd !== 32'hC1) begin
         errors++; $display("FAIL b2b_b1 got we=%b adr=%h wd=%h want 1 404 c1", vif.mem_we, vif.mem_adr, vif.mem_wd);
      end
      $display("b2b: second store committed adr=%h wd=%h", vif.mem_adr, vif.mem_wd);
      tick();
      tick();
   endtask

   task automatic test_wrap();
      logic [31:0] adrs [3] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
      issue(32'hFFFF_FFF8, 4'd3, pack5(32'hD0, 32'hD1, 32'hD2, 32'h0, 32'h0));
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (vif.mem_we !== 1'b1 || vif.mem_adr !== adrs[i] || vif.mem_wd !== 32'hD0 + 32'(i)) begin
            errors++;
            $display("FAIL wrap_lane%0d got we=%b adr=%h wd=%h want 1 %h %h",
                     i, vif.mem_we, vif.mem_adr, vif.mem_wd, adrs[i], 32'hD0 + 32'(i));
         end
         $display("wrap: lane %0d adr=%h", i, vif.mem_adr);
         tick();
      end
      checks++;
      if (vif.done !== 1'b1 || vif.mem_we !== 1'b0) begin
         errors++; $display("FAIL wrap_done got done=%b we=%b want 1 0", vif.done, vif.mem_we);
      end
      tick();
   endtask

   task automatic test_reset_mid();
      int bad_we;
      int bad_done;
      bad_we   = 0;
      bad_done = 0;
      issue(32'h500, 4'd5, pack5(32'hE0, 32'hE1, 32'hE2, 32'hE3, 32'hE4));
      tick();
      tick();
      checks++;
      if (vif.mem_we !== 1'b1 || vif.mem_adr !== 32'h508) begin
         errors++; $display("FAIL mid_lane2 got we=%b adr=%h want 1 508", vif.mem_we, vif.mem_adr);
      end
      #2 reset = 1'b1;
      #1;
      checks++;
      if (vif.mem_we !== 1'b0 || vif.busy !== 1'b0 || vif.req_ready !== 1'b1 || vif.done !== 1'b0) begin
         errors++; $display("FAIL mid_abort got we=%b busy=%b ready=%b done=%b want 0 0 1 0",
                            vif.mem_we, vif.busy, vif.req_ready, vif.done);
      end
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (vif.mem_we !== 1'b0) bad_we++;
         if (vif.done !== 1'b0) bad_done++;
      end
      checks++;
      if (bad_we != 0 || bad_done != 0) begin
         errors++; $display("FAIL mid_quiet got we_cycles=%0d done_cycles=%0d want 0 0", bad_we, bad_done);
      end
      $display("mid: aborted, idle cycles clean");
   endtask

`ifdef VSTORE_MASK_EN
   task automatic test_mask();
      logic [4:0] m;
      m = 5'b10101;
      vif.req_mask = m;
      issue(32'h600, 4'd5, pack5(32'hF0, 32'hF1, 32'hF2, 32'hF3, 32'hF4));
      vif.req_mask = '0;
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (vif.mem_we !== m[i] || vif.mem_adr !== 32'h600 + 32'(4*i)) begin
            errors++;
            $display("FAIL mask_lane%0d got we=%b adr=%h want %b %h", i, vif.mem_we, vif.mem_adr, m[i], 32'h600 + 32'(4*i));
         end
         if (m[i]) begin
            checks++;
            if (vif.mem_wd !== 32'hF0 + 32'(i)) begin
               errors++; $display("FAIL mask_data%0d got %h want %h", i, vif.mem_wd, 32'hF0 + 32'(i));
            end
         end
         $display("mask: lane %0d we=%b adr=%h", i, vif.mem_we, vif.mem_adr);
         tick();
      end
      checks++;
      if (vif.done !== 1'b1 || vif.mem_we !== 1'b0) begin
         errors++; $display("FAIL mask_done got done=%b we=%b want 1 0", vif.done, vif.mem_we);
      end
      tick();
   endtask
`endif

   initial begin
      checks        = 0;
      errors        = 0;
      reset         = 1'b1;
      vif.req_valid = 1'b0;
      vif.req_base  = '0;
      vif.req_len   = '0;
      vif.req_data  = '0;
`ifdef VSTORE_MASK_EN
      vif.req_mask  = '1;
`endif
      test_reset();
      test_basic();
      test_zero_len();
      test_clamp_align();
      test_back_to_back();
      test_wrap();
`ifdef VSTORE_MASK_EN
      vif.req_mask = '1;
`endif
      test_reset_mid();
`ifdef VSTORE_MASK_EN
      test_mask();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
